// File: rtl/fs_word_sender.sv
// Dual-rail, four-phase word serialiser: each bit is driven on one rail, held
// until the receiver acks, then returned to zero before the next bit.
module fs_word_sender #(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ack,
  output logic             bit0,
  output logic             bit1,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RTZ, DONE} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [WIDTH-1:0]       sh, sh_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   last, cur_nx;
  logic                   bit0_nx, bit1_nx, a_nx, b_nx, busy_nx, done_nx, err_nx;

  // ack arrives from another clock domain; only the last flop is used
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else begin
      sync_q[0] <= ack;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign last  = (cnt == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  // next-state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load)   state_nx = DRIVE;
      DRIVE:   if (ack_s)  state_nx = RTZ;
      RTZ:     if (!ack_s) state_nx = last ? DONE : DRIVE;
      DONE:                state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // shift register and bit counter
  always_comb begin
    sh_nx  = sh;
    cnt_nx = cnt;
    if (state == IDLE && load) begin
      sh_nx  = data;
      cnt_nx = '0;
    end else if (state == RTZ && !ack_s && !last) begin
      sh_nx  = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
      cnt_nx = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      sh  <= sh_nx;
      cnt <= cnt_nx;
    end

  // outputs are computed from the next state so they can all be registered
  always_comb begin
    cur_nx  = (MSB_FIRST != 0) ? sh_nx[WIDTH-1] : sh_nx[0];
    a_nx    = (state_nx == DRIVE);
    b_nx    = (state_nx == RTZ);
    bit1_nx = a_nx &  cur_nx;
    bit0_nx = a_nx & ~cur_nx;
    busy_nx = a_nx | b_nx;
    done_nx = (state_nx == DONE);
    err_nx  = err;
    // a stray ack outranks the clear from a load accepted on the same edge
    if ((state == IDLE || state == DONE) && ack_s) err_nx = 1'b1;
    else if (state == IDLE && load)                err_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bit0 <= 1'b0;
      bit1 <= 1'b0;
      A    <= 1'b0;
      B    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      bit0 <= bit0_nx;
      bit1 <= bit1_nx;
      A    <= a_nx;
      B    <= b_nx;
      busy <= busy_nx;
      done <= done_nx;
      err  <= err_nx;
    end
endmodule

// File: tb/tb_fs_word_sender.sv
// Bench for fs_word_sender: three instances (LSB-first, MSB-first, WIDTH=1)
// driven by a compliant four-phase receiver; expected bits flow through a queue.
module tb_fs_word_sender;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] load, ack;
  logic [3:0] data0, data1;
  logic       data2;
  wire  [2:0] b0, b1, aa, bb, bsy, dn, er;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  bit   reload_in_done = 1'b0;

  always #5 clk = ~clk;

  fs_word_sender #(.WIDTH(4), .MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .reset(reset), .load(load[0]), .data(data0), .ack(ack[0]),
    .bit0(b0[0]), .bit1(b1[0]), .A(aa[0]), .B(bb[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]));

  fs_word_sender #(.WIDTH(4), .MSB_FIRST(1), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .reset(reset), .load(load[1]), .data(data1), .ack(ack[1]),
    .bit0(b0[1]), .bit1(b1[1]), .A(aa[1]), .B(bb[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]));

  fs_word_sender #(.WIDTH(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_w1 (
    .clk(clk), .reset(reset), .load(load[2]), .data(data2), .ack(ack[2]),
    .bit0(b0[2]), .bit1(b1[2]), .A(aa[2]), .B(bb[2]), .busy(bsy[2]), .done(dn[2]), .err(er[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rails(input int d, input bit want_up, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (((b0[d] | b1[d]) != want_up) && n < 20);
  endtask

  task automatic wait_done(input int d, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (dn[d] !== 1'b1 && n < 20);
  endtask

  // receiver: handshake nbits bits, assuming the first rail is already up
  task automatic run_bits(input int d, input int w, input int nbits);
    int n;
    for (int i = 0; i < nbits; i++) begin
      chk("onehot", b0[d] ^ b1[d], 1);
      chk("A_drive", aa[d], 1);
      chk("busy_drive", bsy[d], 1);
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else                   chk("bit", b1[d], exp_q.pop_front());
      ack[d] = 1'b1;
      wait_rails(d, 1'b0, n);
      chk("rtz_lat", n, 3);
      chk("B_rtz", bb[d], 1);
      chk("A_rtz", aa[d], 0);
      ack[d] = 1'b0;
      if (i < w - 1) begin
        wait_rails(d, 1'b1, n);
        chk("rise_lat", n, 3);
      end else begin
        wait_done(d, n);
        chk("done_lat", n, 3);
        chk("busy_done", bsy[d], 0);
        if (reload_in_done) load[d] = 1'b1;
        @(negedge clk);
        chk("done_pulse", dn[d], 0);
        chk("idle_busy", bsy[d], 0);
        chk("idle_rails", {b0[d], b1[d]}, 0);
      end
    end
  endtask

  task automatic send(input int d, input logic [3:0] word, input int w, input bit msb,
                      input int nbits);
    int n;
    for (int i = 0; i < w; i++) exp_q.push_back(msb ? word[w-1-i] : word[i]);
    case (d)
      0:       data0 = word;
      1:       data1 = word;
      default: data2 = word[0];
    endcase
    load[d] = 1'b1;
    wait_rails(d, 1'b1, n);
    load[d] = 1'b0;
    chk("load_lat", n, 1);
    chk("err_clr", er[d], 0);
    run_bits(d, w, nbits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = '0; ack = '0; data0 = '0; data1 = '0; data2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {b0, b1, aa, bb, bsy, dn, er}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", {bsy, b0, b1, er}, 0);

    // LSB-first 1010: rails bit0, bit1, bit0, bit1
    send(0, 4'b1010, 4, 1'b0, 4);
    chk("err_lsb", er[0], 0);

    // MSB-first 1000: bit1 then three bit0
    send(1, 4'b1000, 4, 1'b1, 4);
    chk("err_msb", er[1], 0);

    // stray ack in IDLE sets a sticky error; next load clears it
    ack[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_set", er[0], 1);
    ack[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_hold", er[0], 1);
    send(0, 4'b0110, 4, 1'b0, 4);
    chk("err_after", er[0], 0);

    // async reset while the second bit (a 1) is on the rails
    send(0, 4'b1010, 4, 1'b0, 1);
    chk("bit1_pre", b1[0], 1);
    #2 reset = 1'b1;
    #1 chk("async_rst", {b0[0], b1[0], aa[0], bb[0], bsy[0], dn[0], er[0]}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    send(0, 4'b0101, 4, 1'b0, 4);

    // WIDTH=1 with a load re-presented during DONE: ignored until IDLE
    reload_in_done = 1'b1;
    send(2, 4'b0001, 1, 1'b0, 1);
    reload_in_done = 1'b0;
    exp_q.push_back(1'b1);
    @(negedge clk);
    load[2] = 1'b0;
    run_bits(2, 1, 1);
    chk("err_w1", er[2], 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
